// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq
//  Description : Sequential binary-to-BCD converter (shift-and-add-3,
//                one bit per clock) with a start/busy/done handshake.
//                bcd_out holds the last completed result.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_CONV = 1'b1;

    localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(1);

    logic [0:0]          r_state;
    logic [WIDTH-1:0]    r_bin_sr;
    logic [4*DIGITS-1:0] r_bcd_sr;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_done;
    logic [4*DIGITS-1:0] r_bcd_out;

    logic [4*DIGITS-1:0] w_adj;
    logic [4*DIGITS-1:0] w_bcd_next;
    logic [WIDTH-1:0]    w_bin_next;
    logic                w_last;

    // Add-3 correction: every digit >= 5 is pre-adjusted so the following
    // doubling carries correctly into the next digit. Max result is 4'hC.
    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_digit
            assign w_adj[4*d +: 4] = (r_bcd_sr[4*d +: 4] >= 4'd5)
                                   ? (r_bcd_sr[4*d +: 4] + 4'd3)
                                   : r_bcd_sr[4*d +: 4];
        end
    endgenerate

    // One double-dabble step: shift the adjusted accumulator and the source
    // left as one long register, the source MSB entering BCD digit 0.
    assign w_bcd_next = {w_adj[4*DIGITS-2:0], r_bin_sr[WIDTH-1]};
    assign w_bin_next = {r_bin_sr[WIDTH-2:0], 1'b0};
    assign w_last     = (r_cnt == c_CNT_LAST);

    assign busy    = (r_state == c_ST_CONV);
    assign done    = r_done;
    assign bcd_out = r_bcd_out;

    // Control FSM and datapath; the last shift publishes the result directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_bin_sr  <= '0;
            r_bcd_sr  <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_bcd_out <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_bin_sr <= bin_in;
                        r_bcd_sr <= '0;
                        r_cnt    <= c_CNT_INIT;
                        r_state  <= c_ST_CONV;
                    end
                end
                c_ST_CONV: begin
                    r_bin_sr <= w_bin_next;
                    r_bcd_sr <= w_bcd_next;
                    r_cnt    <= r_cnt - c_CNT_LAST;
                    if (w_last) begin
                        r_bcd_out <= w_bcd_next;
                        r_done    <= 1'b1;
                        r_state   <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin_to_bcd_seq
//  Description : Self-checking bench for bin_to_bcd_seq. The 8-bit instance
//                is tracked cycle by cycle against a transaction-level model;
//                16-, 4- and 12-bit instances are checked per conversion.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int ncmp  = 0;
    int nfail = 0;

    // ---------------- DUT instances ----------------
    logic        start8 = 1'b0;  logic [7:0]  bin8  = '0;
    logic        busy8, done8;   logic [11:0] bcd8;
    logic        start16 = 1'b0; logic [15:0] bin16 = '0;
    logic        busy16, done16; logic [19:0] bcd16;
    logic        start4 = 1'b0;  logic [3:0]  bin4  = '0;
    logic        busy4, done4;   logic [7:0]  bcd4;
    logic        start12 = 1'b0; logic [11:0] bin12 = '0;
    logic        busy12, done12; logic [15:0] bcd12;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .bin_in(bin8),
        .busy(busy8), .done(done8), .bcd_out(bcd8));
    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .bin_in(bin16),
        .busy(busy16), .done(done16), .bcd_out(bcd16));
    bin_to_bcd_seq #(.WIDTH(4), .DIGITS(2)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .bin_in(bin4),
        .busy(busy4), .done(done4), .bcd_out(bcd4));
    bin_to_bcd_seq #(.WIDTH(12), .DIGITS(4)) u12 (
        .clk(clk), .rst_n(rst_n), .start(start12), .bin_in(bin12),
        .busy(busy12), .done(done12), .bcd_out(bcd12));

    always #5 clk = ~clk;

    // Decimal reference: digit i is (v / 10^i) mod 10.
    function automatic logic [31:0] to_bcd(input longint v, input int digits);
        logic [31:0] r;
        longint      t;
        r = '0;
        t = v;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model of the 8-bit instance ----------------
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [11:0] m_bcd  = '0;
    int          m_left = 0;
    longint      m_val  = 0;

    // Transaction view: accepted when idle, result appears WIDTH edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_bcd <= '0; m_left <= 0; m_val <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start8) begin
                    m_busy <= 1'b1;
                    m_val  <= longint'(bin8);
                    m_left <= 8;
                end
            end else if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_bcd  <= 12'(to_bcd(m_val, 3));
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    // Cycle-by-cycle comparison of the 8-bit instance against the model.
    always @(negedge clk) begin
        chk("u8_busy", 64'(busy8), 64'(m_busy));
        chk("u8_done", 64'(done8), 64'(m_done));
        chk("u8_bcd_out", 64'(bcd8), 64'(m_bcd));
        chk("u8_busy_and_done", 64'(busy8 & done8), 64'd0);
    end

    // ---------------- helpers ----------------
    function automatic logic sel_done(input int w);
        case (w)
            8:       return done8;
            16:      return done16;
            4:       return done4;
            default: return done12;
        endcase
    endfunction

    task automatic pulse(input int w, input longint val);
        case (w)
            8:       begin start8  = 1'b1; bin8  = 8'(val);  end
            16:      begin start16 = 1'b1; bin16 = 16'(val); end
            4:       begin start4  = 1'b1; bin4  = 4'(val);  end
            default: begin start12 = 1'b1; bin12 = 12'(val); end
        endcase
        @(posedge clk);
        #1;
        start8 = 1'b0; start16 = 1'b0; start4 = 1'b0; start12 = 1'b0;
    endtask

    // Counts falling edges until done is seen; the first counted edge is the
    // one in the cycle after the accepting edge, so WIDTH-cycle latency => WIDTH+1.
    task automatic wait_done(input int w, input int max, output int n);
        n = 0;
        for (int k = 1; k <= max; k++) begin
            @(negedge clk);
            if (sel_done(w)) begin
                n = k;
                return;
            end
        end
        ncmp++;
        nfail++;
        $display("FAIL wait_done_w%0d: actual no done within %0d cycles required done", w, max);
    endtask

    task automatic count_dones(input int w, input int cycles, output int c);
        c = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (sel_done(w)) c++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual simulation still running required finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        int c;
        longint v;
        logic ok;

        #2;
        chk("reset_busy", 64'(busy8), 64'd0);
        chk("reset_done", 64'(done8), 64'd0);
        chk("reset_bcd_out", 64'(bcd8), 64'd0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // 255: busy for 8 cycles, one done, 12'h255
        pulse(8, 255);
        wait_done(8, 20, n);
        chk("lat_255", 64'(n), 64'd9);
        chk("res_255", 64'(bcd8), 64'h255);
        count_dones(8, 3, c);
        chk("single_done_255", 64'(c), 64'd0);

        // 0 then 99 back-to-back, second start raised in the done cycle
        pulse(8, 0);
        wait_done(8, 20, n);
        chk("res_0", 64'(bcd8), 64'h000);
        start8 = 1'b1; bin8 = 8'd99;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done(8, 20, n);
        chk("b2b_spacing", 64'(n), 64'd9);
        chk("res_99", 64'(bcd8), 64'h099);

        // start while busy is ignored
        pulse(8, 128);
        repeat (2) @(posedge clk);
        #1;
        pulse(8, 7);
        wait_done(8, 20, n);
        chk("res_128", 64'(bcd8), 64'h128);
        count_dones(8, 12, c);
        chk("no_extra_done", 64'(c), 64'd0);

        // reset mid-conversion
        pulse(8, 200);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(busy8), 64'd0);
        chk("rst_mid_done", 64'(done8), 64'd0);
        chk("rst_mid_bcd_out", 64'(bcd8), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        count_dones(8, 12, c);
        chk("rst_no_done", 64'(c), 64'd0);
        pulse(8, 42);
        wait_done(8, 20, n);
        chk("res_42", 64'(bcd8), 64'h042);

        // WIDTH = 16
        pulse(16, 65535);
        wait_done(16, 30, n);
        chk("lat_w16", 64'(n), 64'd17);
        chk("res_65535", 64'(bcd16), 64'h65535);
        pulse(16, 10000);
        wait_done(16, 30, n);
        chk("res_10000", 64'(bcd16), 64'h10000);

        // WIDTH = 4, exhaustive
        for (int i = 0; i < 16; i++) begin
            pulse(4, i);
            wait_done(4, 10, n);
            chk("w4_sweep", 64'(bcd4), 64'(((i / 10) << 4) | (i % 10)));
        end

        // WIDTH = 12, random regression
        for (int i = 0; i < 1000; i++) begin
            v = longint'($urandom_range(0, 4095));
            pulse(12, v);
            wait_done(12, 20, n);
            chk("w12_random", 64'(bcd12), 64'(to_bcd(v, 4)));
            ok = 1'b1;
            for (int d = 0; d < 4; d++)
                if (bcd12[4*d +: 4] > 4'd9) ok = 1'b0;
            chk("w12_digit_range", 64'(ok), 64'd1);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential multi-digit binary-to-BCD converter controller. It accepts a WIDTH-bit unsigned binary value on a start/busy/done handshake and runs a shift-and-add-3 (double-dabble) datapath one bit per clock. It produces DIGITS packed BCD digits. It sits between binary counters/accumulators and display or BCD-digit consumers, extending the single-digit 4-bit converter to arbitrary widths.

## Interface
- WIDTH, 8: binary input width; legal values are 4 to 32.
- DIGITS, 3: number of BCD output digits. Must be ≥ ceil(WIDTH·log10(2)); no overflow detection is provided.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bin_in  input  WIDTH  unsigned binary operand; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress (state CONV).
- done  output  1  single-cycle pulse marking bcd_out update.
- bcd_out  output  4·DIGITS  packed BCD result; digit 0 in bits [3:0]; holds the last result.

## Operation
- Internal registers:
  - bin_sr (WIDTH bits), shift source.
  - bcd_sr (4·DIGITS bits), accumulator.
  - cnt (ceil(log2(WIDTH+1)) bits), remaining iterations.
  - state ∈ {IDLE, CONV}.
- IDLE:
  - If start is high: bin_sr ← bin_in, bcd_sr ← 0, cnt ← WIDTH, state → CONV.
  - Otherwise hold.
- CONV, each cycle:
  - For every digit of bcd_sr with value ≥ 5, add 3 to that digit (all digits evaluated in parallel, combinationally).
  - Shift the adjusted {bcd_sr, bin_sr} left by 1; bin_sr LSB ← 0.
  - cnt ← cnt − 1.
- On the CONV cycle where cnt == 1, the shift completes the conversion:
  - bcd_out ← final shifted bcd_sr value.
  - done ← 1 for one cycle.
  - state → IDLE.
- start while busy is ignored: no queuing, no effect on the operand in progress.
- An adjusted digit never exceeds 4'b1111 before the shift. Each result digit is always in 0–9 when the DIGITS constraint holds.
- bin_in changing after acceptance has no effect.

## Timing
- Reset values: state = IDLE, busy = 0, done = 0, bcd_out = 0, bcd_sr = 0, bin_sr = 0, cnt = 0.
- start accepted at edge E0. busy is high from E0 through E_WIDTH.
- At E_WIDTH: bcd_out updates, busy falls, and done is high during the cycle following E_WIDTH.
- Latency: done is visible WIDTH cycles after the accepting edge.
- done and busy are never high together. done is registered, not combinational.
- Back-to-back operation:
  - start high during the done cycle is accepted (state is IDLE) at E_WIDTH+1.
  - Sustained throughput is one conversion per WIDTH+1 cycles.
- bcd_out changes only at the completion edge and is stable otherwise, including during a subsequent conversion.
- rst_n low at any time, including mid-conversion:
  - Immediately forces all reset values.
  - Aborts the conversion with no done pulse.
  - bcd_out returns to 0.
- Reset deassertion is assumed synchronized externally. The first start is accepted on the first edge with rst_n high.

## Test plan
- WIDTH = 8, DIGITS = 3, bin_in = 8'd255, one-cycle start → busy high for 8 cycles, then a single done pulse, bcd_out = 12'h255.
- bin_in = 0, then bin_in = 8'd99 back-to-back (second start asserted in the done cycle):
  - First result bcd_out = 12'h000.
  - Second result 12'h099 with done exactly 9 cycles after the first done.
- Start at bin_in = 8'd128, then pulse start with bin_in = 8'd7 at cycle 3 of busy → second request ignored, result 12'h128, exactly one done pulse.
- Reset mid-conversion: start with bin_in = 8'd200, assert rst_n low at cycle 4 → busy = 0, done never pulses, bcd_out = 0. A fresh start with 8'd42 then yields 12'h042.
- Parameter sweep:
  - WIDTH = 16, DIGITS = 5: bin_in = 16'd65535 → 20'h65535 after 16 cycles.
  - WIDTH = 16, DIGITS = 5: 16'd10000 → 20'h10000.
  - WIDTH = 4, DIGITS = 2: all 16 inputs match decimal.
- Random regression: 1000 random bin_in values at WIDTH = 12, DIGITS = 4. bcd_out is checked against a reference decimal conversion; every digit is ≤ 9.
